// File: rtl/brightness_pkg.sv
// Shared types and helpers for the brightness-filter writeback stage.
package brightness_pkg;

    // Default geometry of the output frame and the PE result words.
    localparam int RAM_ADDR_WIDTH_DEF = 6;
    localparam int RAM_DATA_WIDTH_DEF = 8;
    localparam int PE_DATA_WIDTH_DEF  = 16;
    localparam int DEPTH_DEF          = 4;
    localparam int FIFO_DEPTH_DEF     = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WRITE   = 2'd1,
        DONE_ST = 2'd2
    } writer_state_t;

    typedef struct packed {
        logic [7:0] value;
        logic       sat;
    } clamp_result_t;

    // Number of input words that make up one full output frame.
    function automatic int total_words(input int addrWidth, input int depth);
        return (1 << addrWidth) / depth;
    endfunction

    localparam int TOTAL_WORDS = total_words(RAM_ADDR_WIDTH_DEF, DEPTH_DEF);

    // Clamp a sign-extended PE lane into an unsigned byte; sat flags any clipping.
    function automatic clamp_result_t clamp_u8(input logic signed [31:0] lane);
        clamp_result_t r;
        if (lane < 32'sd0) begin
            r.value = 8'd0;
            r.sat   = 1'b1;
        end else if (lane > 32'sd255) begin
            r.value = 8'd255;
            r.sat   = 1'b1;
        end else begin
            r.value = lane[7:0];
            r.sat   = 1'b0;
        end
        return r;
    endfunction

endpackage

// File: rtl/brightness_result_writer_fifo.sv
// Small synchronous FIFO buffering whole PE result words ahead of the serialiser.
module result_fifo #(
    parameter int WIDTH      = 64,
    parameter int FIFO_DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wrPtr_q;
    logic [PTR_W-1:0] rdPtr_q;
    logic [PTR_W:0]   count_q;
    logic             doPush;
    logic             doPop;

    assign full_o  = (count_q == (PTR_W + 1)'(FIFO_DEPTH));
    assign empty_o = (count_q == '0);
    assign doPush  = push_i && !full_o;
    assign doPop   = pop_i && !empty_o;
    assign head_o  = mem[rdPtr_q];

    // Storage array; contents are meaningless while the matching count is zero.
    always_ff @(posedge clk) begin
        if (doPush) begin
            mem[wrPtr_q] <= data_i;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (doPop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({doPush, doPop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/brightness_result_writer.sv
// Writeback stage: serialises clamped PE lanes into the output frame RAM.
module brightness_result_writer
    import brightness_pkg::*;
#(
    parameter int RAM_ADDR_WIDTH = RAM_ADDR_WIDTH_DEF,
    parameter int RAM_DATA_WIDTH = RAM_DATA_WIDTH_DEF,
    parameter int PE_DATA_WIDTH  = PE_DATA_WIDTH_DEF,
    parameter int DEPTH          = DEPTH_DEF,
    parameter int FIFO_DEPTH     = FIFO_DEPTH_DEF
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             start,
    input  logic [PE_DATA_WIDTH*DEPTH-1:0]   in_data,
    input  logic                             in_valid,
    output logic                             in_ready,
    output logic                             ram_we,
    output logic [RAM_ADDR_WIDTH-1:0]        ram_address,
    output logic [RAM_DATA_WIDTH-1:0]        ram_wdata,
    output logic                             busy,
    output logic                             done,
    output logic                             sat_seen
);

    localparam int WORD_WIDTH   = PE_DATA_WIDTH * DEPTH;
    localparam int FRAME_WORDS  = total_words(RAM_ADDR_WIDTH, DEPTH);
    localparam int LANE_W       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int WCNT_W       = $clog2(FRAME_WORDS + 1);

    writer_state_t             state_q;
    logic [RAM_ADDR_WIDTH-1:0] baseAddr_q;
    logic [LANE_W-1:0]         laneIdx_q;
    logic [WCNT_W-1:0]         wordsIn_q;
    logic                      satSeen_q;
    logic                      ramWe_q;
    logic [RAM_ADDR_WIDTH-1:0] ramAddr_q;
    logic [RAM_DATA_WIDTH-1:0] ramWdata_q;

    logic [WORD_WIDTH-1:0]     fifoHead;
    logic                      fifoFull;
    logic                      fifoEmpty;
    logic                      push;
    logic                      pop;
    logic                      drain;
    logic                      lastLane;
    logic                      frameWritten;
    logic [PE_DATA_WIDTH-1:0]  laneSel_d;
    logic signed [31:0]        laneExt_d;
    clamp_result_t             clamp_d;

    assign in_ready     = (state_q == WRITE) && !fifoFull && (wordsIn_q < WCNT_W'(FRAME_WORDS));
    assign push         = in_valid && in_ready;
    assign drain        = (state_q == WRITE) && !fifoEmpty;
    assign lastLane     = (laneIdx_q == LANE_W'(DEPTH - 1));
    assign pop          = drain && lastLane;
    assign frameWritten = ramWe_q && (ramAddr_q == '1);

    result_fifo #(
        .WIDTH      (WORD_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (in_data),
        .head_o  (fifoHead),
        .full_o  (fifoFull),
        .empty_o (fifoEmpty)
    );

    // Pick the current lane of the head word and clamp it to a byte.
    always_comb begin
        laneSel_d = fifoHead[int'(laneIdx_q) * PE_DATA_WIDTH +: PE_DATA_WIDTH];
        laneExt_d = 32'($signed(laneSel_d));
        clamp_d   = clamp_u8(laneExt_d);
    end

    // Frame sequencing, lane/address counters and registered RAM write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            baseAddr_q <= '0;
            laneIdx_q  <= '0;
            wordsIn_q  <= '0;
            satSeen_q  <= 1'b0;
            ramWe_q    <= 1'b0;
            ramAddr_q  <= '0;
            ramWdata_q <= '0;
        end else begin
            ramWe_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q    <= WRITE;
                        baseAddr_q <= '0;
                        laneIdx_q  <= '0;
                        wordsIn_q  <= '0;
                        satSeen_q  <= 1'b0;
                    end
                end
                WRITE: begin
                    if (push) begin
                        wordsIn_q <= wordsIn_q + 1'b1;
                    end
                    if (drain) begin
                        ramWe_q    <= 1'b1;
                        ramAddr_q  <= baseAddr_q + RAM_ADDR_WIDTH'(laneIdx_q);
                        ramWdata_q <= RAM_DATA_WIDTH'(clamp_d.value);
                        if (clamp_d.sat) begin
                            satSeen_q <= 1'b1;
                        end
                        if (lastLane) begin
                            laneIdx_q  <= '0;
                            baseAddr_q <= baseAddr_q + RAM_ADDR_WIDTH'(DEPTH);
                        end else begin
                            laneIdx_q <= laneIdx_q + 1'b1;
                        end
                    end
                    if (frameWritten) begin
                        state_q <= DONE_ST;
                    end
                end
                DONE_ST: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ram_we      = ramWe_q;
    assign ram_address = ramAddr_q;
    assign ram_wdata   = ramWdata_q;
    assign busy        = (state_q == WRITE);
    assign done        = (state_q == DONE_ST);
    assign sat_seen    = satSeen_q;

endmodule

// File: tb/tb_brightness_result_writer.sv
// Scoreboard bench for brightness_result_writer: random PE words, byte-level reference model.
module tb_brightness_result_writer;

    localparam int AW    = 6;
    localparam int DW    = 8;
    localparam int PW    = 16;
    localparam int DEP   = 4;
    localparam int TOTAL = 16;
    localparam int FRAME = 64;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [PW*DEP-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              ram_we;
    logic [AW-1:0]     ram_address;
    logic [DW-1:0]     ram_wdata;
    logic              busy;
    logic              done;
    logic              sat_seen;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    exp_t expQ[$];
    exp_t monExp;
    int   checks = 0;
    int   failures = 0;
    int   cycleCount = 0;
    int   wordIdx = 0;
    bit   expSat = 1'b0;
    int   doneCount = 0;
    int   weCount = 0;
    int   firstWe = 0;
    int   lastWe = 0;
    bit   sawBackpressure = 1'b0;

    brightness_result_writer dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .ram_we      (ram_we),
        .ram_address (ram_address),
        .ram_wdata   (ram_wdata),
        .busy        (busy),
        .done        (done),
        .sat_seen    (sat_seen)
    );

    // Free-running clock and cycle counter used for latency checks.
    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Reference model: a word accepted as word n of the frame becomes bytes at n*DEPTH+i.
    task automatic modelAccept(input logic [PW*DEP-1:0] w);
        logic signed [PW-1:0] lane;
        int   v;
        exp_t e;
        for (int i = 0; i < DEP; i++) begin
            lane   = w[i*PW +: PW];
            v      = lane;
            e.addr = wordIdx * DEP + i;
            e.data = (v < 0) ? 0 : ((v > 255) ? 255 : v);
            if (v < 0 || v > 255) expSat = 1'b1;
            expQ.push_back(e);
        end
        wordIdx++;
    endtask

    function automatic logic [PW-1:0] randLane();
        int v;
        case ($urandom_range(0, 3))
            0, 1:    v = int'($urandom_range(0, 255));
            2:       v = -int'($urandom_range(1, 32768));
            default: v = int'($urandom_range(256, 32767));
        endcase
        return PW'(v);
    endfunction

    function automatic logic [PW*DEP-1:0] randWord();
        logic [PW*DEP-1:0] w;
        for (int i = 0; i < DEP; i++) w[i*PW +: PW] = randLane();
        return w;
    endfunction

    // Offer one word until accepted; hold keeps in_valid asserted afterwards.
    task automatic applyStimulus(input logic [PW*DEP-1:0] w, input bit hold);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = w;
            #1;
            if (in_ready) begin
                ok = 1'b1;
                modelAccept(w);
                @(posedge clk);
                #1;
            end else if (busy) begin
                sawBackpressure = 1'b1;
            end
        end
        if (!ok) checkOutput("accept_timeout", 0, 1);
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic startFrame();
        @(negedge clk);
        wordIdx   = 0;
        expSat    = 1'b0;
        doneCount = 0;
        weCount   = 0;
        expQ.delete();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        checkOutput("start_busy", busy, 1);
        checkOutput("start_sat_clear", sat_seen, 0);
    endtask

    task automatic waitFrame();
        for (int t = 0; t < 400 && doneCount == 0; t++) @(negedge clk);
        checkOutput("frame_done_seen", doneCount, 1);
        repeat (3) @(negedge clk);
        checkOutput("done_pulse_count", doneCount, 1);
        checkOutput("frame_writes", weCount, FRAME);
        checkOutput("idle_after_done", busy, 0);
        checkOutput("done_low_after_pulse", done, 0);
    endtask

    task automatic checkResetOutputs();
        checkOutput("rst_ram_we", ram_we, 0);
        checkOutput("rst_ram_address", ram_address, 0);
        checkOutput("rst_ram_wdata", ram_wdata, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_done", done, 0);
        checkOutput("rst_sat_seen", sat_seen, 0);
        checkOutput("rst_in_ready", in_ready, 0);
    endtask

    // Monitor: every RAM write is popped from the scoreboard; done timing checked against last write.
    always @(negedge clk) begin
        if (!reset) begin
            if (ram_we) begin
                if (weCount == 0) firstWe = cycleCount;
                weCount++;
                lastWe = cycleCount;
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_write_addr", int'(ram_address), -1);
                end else begin
                    monExp = expQ.pop_front();
                    checkOutput("write_addr", int'(ram_address), monExp.addr);
                    checkOutput("write_data", int'(ram_wdata), monExp.data);
                end
            end
            if (done) begin
                doneCount++;
                checkOutput("done_latency", cycleCount, lastWe + 1);
                checkOutput("done_sat_seen", sat_seen, int'(expSat));
                checkOutput("done_queue_empty", expQ.size(), 0);
            end
        end
    end

    initial begin
        logic [PW*DEP-1:0] w;
        reset    = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        checkResetOutputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;

        $display("[TB] test 1: ascending frame");
        startFrame();
        for (int k = 0; k < TOTAL; k++) begin
            w = {PW'(40 + k), PW'(30 + k), PW'(20 + k), PW'(10 + k)};
            applyStimulus(w, 1'b0);
        end
        waitFrame();

        $display("[TB] test 2: clamp word then random words");
        startFrame();
        w = {16'sh0123, 16'shFFFF, 16'sd255, 16'sd0};
        applyStimulus(w, 1'b0);
        for (int k = 1; k < TOTAL; k++) applyStimulus(randWord(), 1'b0);
        waitFrame();

        $display("[TB] test 3: continuous valid");
        sawBackpressure = 1'b0;
        startFrame();
        for (int k = 0; k < TOTAL; k++) applyStimulus(randWord(), 1'b1);
        in_valid = 1'b0;
        waitFrame();
        checkOutput("backpressure_seen", sawBackpressure, 1);
        checkOutput("contiguous_span", lastWe - firstWe + 1, FRAME);

        $display("[TB] test 4: ignored valid and start");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = randWord();
            #1;
            checkOutput("idle_in_ready", in_ready, 0);
            checkOutput("idle_ram_we", ram_we, 0);
        end
        in_valid = 1'b0;
        startFrame();
        for (int k = 0; k < TOTAL; k++) begin
            applyStimulus(randWord(), 1'b0);
            if (k == 6) begin
                @(negedge clk);
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = randWord();
            #1;
            checkOutput("in_ready_after_total", in_ready, 0);
        end
        in_valid = 1'b0;
        waitFrame();

        $display("[TB] test 5: reset mid-frame");
        startFrame();
        for (int k = 0; k < 5; k++) begin
            w = randWord();
            w[PW-1:0] = 16'hFF00;
            applyStimulus(w, 1'b0);
        end
        @(negedge clk);
        @(posedge clk);
        #1;
        checkOutput("sat_before_reset", sat_seen, 1);
        #1;
        reset = 1'b1;
        #1;
        expQ.delete();
        checkResetOutputs();
        @(negedge clk);
        reset = 1'b0;
        startFrame();
        for (int k = 0; k < TOTAL; k++) applyStimulus(randWord(), 1'b0);
        waitFrame();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
